// File: rtl/apb_master_arbiter.sv
// APB N-to-1 master arbiter for the SoC peripheral segment.
// Round-robin grant, one transfer at a time, with an optional ACCESS timeout.
module apb_master_arbiter #(
  parameter int N_MST          = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_MST-1:0]            mst_psel_i,
  input  logic [N_MST-1:0]            mst_penable_i,
  input  logic [N_MST-1:0]            mst_pwrite_i,
  input  logic [N_MST*ADDR_WIDTH-1:0] mst_paddr_i,
  input  logic [N_MST*DATA_WIDTH-1:0] mst_pwdata_i,
  output logic [N_MST-1:0]            mst_pready_o,
  output logic [N_MST*DATA_WIDTH-1:0] mst_prdata_o,
  output logic [N_MST-1:0]            mst_pslverr_o,
  output logic                        slv_psel_o,
  output logic                        slv_penable_o,
  output logic                        slv_pwrite_o,
  output logic [ADDR_WIDTH-1:0]       slv_paddr_o,
  output logic [DATA_WIDTH-1:0]       slv_pwdata_o,
  input  logic                        slv_pready_i,
  input  logic [DATA_WIDTH-1:0]       slv_prdata_i,
  input  logic                        slv_pslverr_i,
  output logic                        busy_o,
  output logic [$clog2(N_MST)-1:0]    grant_o,
  output logic                        timeout_o
);

  localparam int GW = $clog2(N_MST);
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit T_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] T_LAST =
    T_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [GW-1:0] LAST_IDX = GW'(N_MST - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [GW-1:0]   ptr_q;
  logic [GW-1:0]   gnt_q;
  logic [CW-1:0]   cnt_q;
  logic [GW-1:0]   idx;
  logic [GW-1:0]   pick;
  logic            pick_vld;
  logic            done;
  logic            tmo;
  logic            hit;

  logic [ADDR_WIDTH-1:0] addr_a [N_MST];
  logic [DATA_WIDTH-1:0] wdat_a [N_MST];
  logic [DATA_WIDTH-1:0] rdat_a [N_MST];

  for (genvar g = 0; g < N_MST; g++) begin : g_unpack
    assign addr_a[g] =
      mst_paddr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdat_a[g] =
      mst_pwdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign mst_prdata_o[g*DATA_WIDTH +: DATA_WIDTH] =
      rdat_a[g];
  end

  // search starts one past the last grant, wrapping
  always_comb begin
    idx      = ptr_q;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < N_MST; i++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (!pick_vld && mst_psel_i[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (slv_pready_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (T_EN && cnt_q == T_LAST) begin
          done    = 1'b1;
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ptr_q        <= LAST_IDX;
      gnt_q        <= '0;
      cnt_q        <= '0;
      slv_pwrite_o <= 1'b0;
      slv_paddr_o  <= '0;
      slv_pwdata_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_vld) begin
        ptr_q        <= pick;
        gnt_q        <= pick;
        slv_pwrite_o <= mst_pwrite_i[pick];
        slv_paddr_o  <= addr_a[pick];
        slv_pwdata_o <= wdat_a[pick];
      end
      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if (state_q == ACCESS && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // a master that dropped its request mid-transfer loses the response
  assign hit = done && mst_psel_i[gnt_q] && mst_penable_i[gnt_q];

  always_comb begin
    mst_pready_o  = '0;
    mst_pslverr_o = '0;
    rdat_a        = '{default: '0};
    if (hit) begin
      mst_pready_o[gnt_q]  = 1'b1;
      mst_pslverr_o[gnt_q] = tmo | slv_pslverr_i;
      rdat_a[gnt_q]        = tmo ? '0 : slv_prdata_i;
    end
  end

  assign slv_psel_o    = (state_q != IDLE);
  assign slv_penable_o = (state_q == ACCESS);
  assign busy_o        = (state_q != IDLE);
  assign grant_o       = gnt_q;
  assign timeout_o     = tmo;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed scoreboard bench for apb_master_arbiter.
// Main DUT uses a 16-cycle timeout; a second copy runs with timeout off.
module tb_apb_master_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    psel   = '0;
  logic [N-1:0]    pen    = '0;
  logic [N-1:0]    pwr    = '0;
  logic [N*AW-1:0] paddr  = '0;
  logic [N*DW-1:0] pwdata = '0;

  logic [N-1:0]    mst_pready;
  logic [N*DW-1:0] mst_prdata;
  logic [N-1:0]    mst_pslverr;
  logic            s_psel, s_pen, s_pwr;
  logic [AW-1:0]   s_paddr;
  logic [DW-1:0]   s_pwdata;
  logic            s_ready;
  logic [DW-1:0]   s_rdata = '0;
  logic            s_err   = 1'b0;
  logic            busy, timeout;
  logic [0:0]      grant;

  logic [N-1:0]    d2_pready;
  logic [N*DW-1:0] d2_prdata;
  logic [N-1:0]    d2_pslverr;
  logic            d2_psel, d2_pen, d2_pwr;
  logic [AW-1:0]   d2_paddr;
  logic [DW-1:0]   d2_pwdata;
  logic            d2_busy, d2_to;
  logic [0:0]      d2_grant;

  bit hang   = 1'b0;
  int wait_n = 0;
  int acc_cnt;

  assign s_ready = s_pen && !hang && (acc_cnt >= wait_n);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) acc_cnt <= 0;
    else if (s_psel && s_pen) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;

  apb_master_arbiter #(
    .N_MST(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mst_psel_i(psel), .mst_penable_i(pen),
    .mst_pwrite_i(pwr), .mst_paddr_i(paddr),
    .mst_pwdata_i(pwdata),
    .mst_pready_o(mst_pready), .mst_prdata_o(mst_prdata),
    .mst_pslverr_o(mst_pslverr),
    .slv_psel_o(s_psel), .slv_penable_o(s_pen),
    .slv_pwrite_o(s_pwr), .slv_paddr_o(s_paddr),
    .slv_pwdata_o(s_pwdata), .slv_pready_i(s_ready),
    .slv_prdata_i(s_rdata), .slv_pslverr_i(s_err),
    .busy_o(busy), .grant_o(grant), .timeout_o(timeout)
  );

  apb_master_arbiter #(
    .N_MST(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(0)
  ) u_nto (
    .clk_i(clk), .rst_ni(rst_n),
    .mst_psel_i(psel), .mst_penable_i(pen),
    .mst_pwrite_i(pwr), .mst_paddr_i(paddr),
    .mst_pwdata_i(pwdata),
    .mst_pready_o(d2_pready), .mst_prdata_o(d2_prdata),
    .mst_pslverr_o(d2_pslverr),
    .slv_psel_o(d2_psel), .slv_penable_o(d2_pen),
    .slv_pwrite_o(d2_pwr), .slv_paddr_o(d2_paddr),
    .slv_pwdata_o(d2_pwdata), .slv_pready_i(1'b0),
    .slv_prdata_i(32'h0), .slv_pslverr_i(1'b0),
    .busy_o(d2_busy), .grant_o(d2_grant), .timeout_o(d2_to)
  );

  typedef struct {
    int          m;
    logic [AW-1:0] addr;
    logic        wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic        err;
    logic        to;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   o;
  int   errors  = 0;
  int   checks  = 0;
  int   to_cnt  = 0;
  int   d2_pcnt = 0;
  int   d2_tcnt = 0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp_v);
    end
  endtask

  task automatic push(int m, logic [AW-1:0] a, logic wr,
                      logic [DW-1:0] wd, logic [DW-1:0] rd,
                      logic err, logic to, int acc);
    exp_t x;
    x.m = m; x.addr = a; x.wr = wr; x.wdata = wd;
    x.rdata = rd; x.err = err; x.to = to; x.acc = acc;
    sb.push_back(x);
  endtask

  task automatic xfer(int m, logic wr, logic [AW-1:0] a,
                      logic [DW-1:0] d);
    int n;
    psel[m] = 1'b1;
    pen[m]  = 1'b0;
    pwr[m]  = wr;
    paddr[m*AW +: AW]  = a;
    pwdata[m*DW +: DW] = d;
    @(posedge clk); #1;
    pen[m] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (mst_pready[m]) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $error("FAIL xfer_wait m%0d: observed no pready expected pready within 200", m);
        break;
      end
    end
    @(posedge clk); #1;
    psel[m] = 1'b0;
    pen[m]  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (timeout) to_cnt++;
      if (|d2_pready) d2_pcnt++;
      if (d2_to) d2_tcnt++;
      if (|mst_pready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected: observed pready %b expected none",
                 mst_pready);
        end else begin
          e = sb.pop_front();
          o = 1 - e.m;
          chk("sb_pready", mst_pready, 64'(1) << e.m);
          chk("sb_grant", grant, e.m);
          chk("sb_prdata", mst_prdata[e.m*DW +: DW], e.rdata);
          chk("sb_pslverr", mst_pslverr[e.m], e.err);
          chk("sb_timeout", timeout, e.to);
          chk("sb_paddr", s_paddr, e.addr);
          chk("sb_pwrite", s_pwr, e.wr);
          chk("sb_pwdata", s_pwdata, e.wdata);
          chk("sb_acc_cycles", acc_cnt, e.acc);
          chk("iso_prdata", mst_prdata[o*DW +: DW], 0);
          chk("iso_pslverr", mst_pslverr[o], 0);
        end
      end else begin
        chk("quiet_prdata", mst_prdata, 0);
        chk("quiet_flags", {mst_pslverr, timeout}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed hang expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs",
        {s_psel, s_pen, s_pwr, busy, grant, timeout,
         mst_pready, mst_pslverr}, 0);
    chk("rst_paddr", s_paddr, 0);
    chk("rst_pwdata", s_pwdata, 0);
    chk("rst_prdata", mst_prdata, 0);

    // T1: single write, zero-wait slave
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push(0, 32'h1A10_3000, 1'b1, 32'h12, 32'h0, 1'b0, 1'b0, 0);
    psel[0] = 1'b1;
    pwr[0]  = 1'b1;
    paddr[0 +: AW]  = 32'h1A10_3000;
    pwdata[0 +: DW] = 32'h12;
    @(negedge clk);
    chk("t1_c0_psel", s_psel, 0);
    @(posedge clk); #1 pen[0] = 1'b1;
    @(negedge clk);
    chk("t1_c1_sel_en", {s_psel, s_pen, busy}, 3'b101);
    @(negedge clk);
    chk("t1_c2_sel_en", {s_psel, s_pen}, 2'b11);
    chk("t1_c2_pready", mst_pready, 2'b01);
    @(posedge clk); #1;
    psel[0] = 1'b0;
    pen[0]  = 1'b0;
    @(negedge clk);
    chk("t1_c3_idle", {busy, s_psel, s_pen}, 0);
    chk("t1_c3_hold", s_paddr, 32'h1A10_3000);

    // T2: both request from reset; expect 0,1,0,1
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    s_rdata = 32'h1111_1111;
    push(0, 32'h1A10_0000, 1'b1, 32'h100, s_rdata, 1'b0, 1'b0, 0);
    push(1, 32'h1A11_0000, 1'b0, 32'h200, s_rdata, 1'b0, 1'b0, 0);
    push(0, 32'h1A10_0004, 1'b1, 32'h101, s_rdata, 1'b0, 1'b0, 0);
    push(1, 32'h1A11_0004, 1'b0, 32'h201, s_rdata, 1'b0, 1'b0, 0);
    fork
      begin
        xfer(0, 1'b1, 32'h1A10_0000, 32'h100);
        xfer(0, 1'b1, 32'h1A10_0004, 32'h101);
      end
      begin
        xfer(1, 1'b0, 32'h1A11_0000, 32'h200);
        xfer(1, 1'b0, 32'h1A11_0004, 32'h201);
      end
    join
    chk("t2_sb_drained", sb.size(), 0);

    // T3: read with five wait states
    s_rdata = 32'hCAFE_F00D;
    wait_n  = 5;
    push(1, 32'h1A10_4000, 1'b0, 32'h0, 32'hCAFE_F00D,
         1'b0, 1'b0, 5);
    xfer(1, 1'b0, 32'h1A10_4000, 32'h0);
    wait_n = 0;

    // T5: slave error
    s_err   = 1'b1;
    s_rdata = 32'h5555_0000;
    push(0, 32'h1A10_5000, 1'b1, 32'hBEEF, 32'h5555_0000,
         1'b1, 1'b0, 0);
    xfer(0, 1'b1, 32'h1A10_5000, 32'hBEEF);
    s_err = 1'b0;

    // T4: hung slave, timeout on 16th ACCESS cycle
    hang = 1'b1;
    push(0, 32'h1A10_6000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 15);
    xfer(0, 1'b0, 32'h1A10_6000, 32'h0);
    @(negedge clk);
    chk("t4_psel_drop", {s_psel, busy}, 0);
    chk("t4_one_pulse", to_cnt, 1);
    chk("t4_sb_drained", sb.size(), 0);

    // T6: reset during ACCESS
    @(posedge clk); #1;
    psel[1] = 1'b1;
    paddr[AW +: AW] = 32'h1A10_7000;
    @(posedge clk); #1 pen[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_access", {s_psel, s_pen}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_outs",
        {s_psel, s_pen, s_pwr, busy, grant, timeout,
         mst_pready, mst_pslverr}, 0);
    chk("t6_rst_paddr", s_paddr, 0);
    chk("t6_rst_prdata", mst_prdata, 0);
    psel = '0;
    pen  = '0;
    hang = 1'b0;
    s_rdata = 32'h7777_0000;
    @(posedge clk); #1 rst_n = 1'b1;
    push(0, 32'h1A10_8000, 1'b1, 32'h80, s_rdata, 1'b0, 1'b0, 0);
    push(1, 32'h1A10_9000, 1'b1, 32'h90, s_rdata, 1'b0, 1'b0, 0);
    fork
      xfer(0, 1'b1, 32'h1A10_8000, 32'h80);
      xfer(1, 1'b1, 32'h1A10_9000, 32'h90);
    join
    chk("t6_sb_drained", sb.size(), 0);

    // timeout disabled copy must still be waiting
    repeat (1000) @(posedge clk);
    @(negedge clk);
    chk("t4b_stuck", {d2_busy, d2_psel, d2_pen}, 3'b111);
    chk("t4b_no_pready", d2_pcnt, 0);
    chk("t4b_no_timeout", d2_tcnt, 0);
    chk("t4b_main_to", to_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
